cell_pos_reader: RTL and testbench

//  Read-side initiator for one per-cell position RAM (2-cycle read latency, addr 0 = particle count, addr 1..N = {posz,posy,posx}).
//  On start: fetches the count, then streams particles 1..N out on a valid/ready interface to the force/motion-update pipeline.

---
 rtl/cell_pos_reader_pkg.sv | 31 +++
 rtl/cell_pos_reader_if.sv | 30 +++
 rtl/cell_pos_rd_fifo.sv | 52 +++++
 rtl/cell_pos_reader.sv | 160 ++++++++++++++++
 tb/tb_cell_pos_reader.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/cell_pos_reader_pkg.sv
// Shared types and constants for the per-cell position RAM reader.
// CELL_POS_RD_ID_EN adds the particle RAM address to each FIFO entry.
package cell_pos_reader_pkg;

    localparam int unsigned DATA_WIDTH       = 96;
    localparam int unsigned ADDR_WIDTH       = 8;
    localparam int unsigned PARTICLE_NUM_DEF = 220;
    localparam int unsigned FIFO_DEPTH_DEF   = 4;
    localparam int unsigned RD_LATENCY       = 2;

    localparam logic [ADDR_WIDTH-1:0] COUNT_ADDR = '0;

    typedef enum logic [2:0] {
        IDLE,
        RD_CNT,
        WAIT_CNT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    // One buffered particle: position plus end-of-cell marker (and source address)
    typedef struct packed {
`ifdef CELL_POS_RD_ID_EN
        logic [ADDR_WIDTH-1:0] id;
`endif
        logic                  last;
        logic [DATA_WIDTH-1:0] pos;
    } pos_entry_t;

endpackage

// File: rtl/cell_pos_reader_if.sv
// Valid/ready particle stream from the cell reader to the pos cache fill logic.
// CELL_POS_RD_ID_EN adds out_id carrying the particle's RAM address.
interface cell_pos_reader_if;
    import cell_pos_reader_pkg::*;

    logic [DATA_WIDTH-1:0] out_pos;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;
`ifdef CELL_POS_RD_ID_EN
    logic [ADDR_WIDTH-1:0] out_id;
`endif

    modport master (
`ifdef CELL_POS_RD_ID_EN
        output out_id,
`endif
        output out_pos, out_valid, out_last,
        input  out_ready
    );

    modport slave (
`ifdef CELL_POS_RD_ID_EN
        input  out_id,
`endif
        input  out_pos, out_valid, out_last,
        output out_ready
    );

endinterface

// File: rtl/cell_pos_rd_fifo.sv
// Synchronous FIFO for particle entries; head is read straight from the entry registers.
module cell_pos_rd_fifo
    import cell_pos_reader_pkg::*;
#(
    parameter  int unsigned DEPTH = FIFO_DEPTH_DEF,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  pos_entry_t       i_data,
    input  logic             i_pop,
    output pos_entry_t       o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    pos_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/cell_pos_reader.sv
// Reads the particle count from a cell position RAM, then streams particles 1..N downstream.
// CELL_POS_RD_ID_EN adds out_id (particle RAM address) to the output stream.
module cell_pos_reader
    import cell_pos_reader_pkg::*;
#(
    parameter int unsigned PARTICLE_NUM = PARTICLE_NUM_DEF,
    parameter int unsigned FIFO_DEPTH   = FIFO_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  cnt_err,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    cell_pos_reader_if.master     out_if
);

    localparam int unsigned           CNT_W     = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_wait_second;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cnt_err;
    logic [ADDR_WIDTH-1:0] r_count;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [RD_LATENCY-1:0] r_ret_vld;
    logic [RD_LATENCY-1:0] r_ret_last;
`ifdef CELL_POS_RD_ID_EN
    logic [ADDR_WIDTH-1:0] r_ret_id [RD_LATENCY];
`endif
    logic [CNT_W-1:0]      w_fifo_count;
    logic [CNT_W:0]        w_inflight;
    logic [CNT_W:0]        w_credit_used;
    logic                  w_issue;
    logic                  w_fifo_valid;
    logic                  w_pop;
    logic                  w_drained;
    logic                  w_clamp_hit;
    logic [ADDR_WIDTH-1:0] w_raw_count;
    logic [ADDR_WIDTH-1:0] w_clamped;
    pos_entry_t            w_push_entry;
    pos_entry_t            w_head;

    assign w_raw_count   = ram_q[ADDR_WIDTH-1:0];
    assign w_clamp_hit   = (w_raw_count > MAX_COUNT);
    assign w_clamped     = w_clamp_hit ? MAX_COUNT : w_raw_count;

    // Reads only issue while buffered plus in-flight words leave a free FIFO slot
    assign w_inflight    = (CNT_W + 1)'($countones(r_ret_vld));
    assign w_credit_used = {1'b0, w_fifo_count} + w_inflight;
    assign w_issue       = (r_state == STREAM) && (w_credit_used < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_pop         = w_fifo_valid && out_if.out_ready;
    assign w_drained     = (w_inflight == '0) &&
                           ((w_fifo_count == '0) || ((w_fifo_count == CNT_W'(1)) && w_pop));

    assign ram_rden       = (r_state == RD_CNT) || w_issue;
    assign ram_address    = r_addr;
    assign ram_wren       = 1'b0;
    assign busy           = r_busy;
    assign done           = r_done;
    assign cnt_err        = r_cnt_err;
    assign particle_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (start) w_state_nxt = RD_CNT;
            RD_CNT:   w_state_nxt = WAIT_CNT;
            WAIT_CNT: if (r_wait_second) w_state_nxt = (w_clamped == '0) ? DONE : STREAM;
            STREAM:   if (w_issue && (r_addr == r_count)) w_state_nxt = DRAIN;
            DRAIN:    if (w_drained) w_state_nxt = DONE;
            DONE:     w_state_nxt = IDLE;
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_second <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cnt_err     <= 1'b0;
            r_count       <= '0;
            r_addr        <= '0;
            r_ret_vld     <= '0;
            r_ret_last    <= '0;
        end else begin
            r_busy        <= (w_state_nxt != IDLE);
            r_done        <= (w_state_nxt == DONE);
            r_wait_second <= (r_state == WAIT_CNT) && !r_wait_second;
            if ((r_state == IDLE) && start) begin
                r_addr    <= COUNT_ADDR;
                r_cnt_err <= 1'b0;
            end else if ((r_state == WAIT_CNT) && r_wait_second) begin
                r_count   <= w_clamped;
                r_cnt_err <= w_clamp_hit;
                r_addr    <= ADDR_WIDTH'(1);
            end else if (w_issue) begin
                r_addr    <= r_addr + ADDR_WIDTH'(1);
            end
            // Return tracker: one stage per cycle of RAM read latency
            r_ret_vld  <= {r_ret_vld[RD_LATENCY-2:0], w_issue};
            r_ret_last <= {r_ret_last[RD_LATENCY-2:0], (r_addr == r_count)};
        end
    end

`ifdef CELL_POS_RD_ID_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LATENCY; i++) r_ret_id[i] <= '0;
        end else begin
            r_ret_id[0] <= r_addr;
            for (int i = 1; i < RD_LATENCY; i++) r_ret_id[i] <= r_ret_id[i-1];
        end
    end
`endif

    always_comb begin
        w_push_entry      = '0;
        w_push_entry.pos  = ram_q;
        w_push_entry.last = r_ret_last[RD_LATENCY-1];
`ifdef CELL_POS_RD_ID_EN
        w_push_entry.id   = r_ret_id[RD_LATENCY-1];
`endif
    end

    cell_pos_rd_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_ret_vld[RD_LATENCY-1]),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    assign out_if.out_pos   = w_head.pos;
    assign out_if.out_valid = w_fifo_valid;
    assign out_if.out_last  = w_head.last;
`ifdef CELL_POS_RD_ID_EN
    assign out_if.out_id    = w_head.id;
`endif

endmodule

// File: tb/tb_cell_pos_reader.sv
// Directed bench for cell_pos_reader: RAM model with 2-cycle latency and an expected-word queue.
module tb_cell_pos_reader;
    import cell_pos_reader_pkg::*;

    localparam int PN = 220;
    localparam int FD = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  cnt_err;
    logic [ADDR_WIDTH-1:0] particle_count;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_rden;
    logic                  ram_wren;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [DATA_WIDTH-1:0] q1;
    logic [DATA_WIDTH-1:0] mem [256];

    cell_pos_reader_if u_if ();

    cell_pos_reader #(
        .PARTICLE_NUM (PN),
        .FIFO_DEPTH   (FD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .cnt_err        (cnt_err),
        .particle_count (particle_count),
        .ram_address    (ram_address),
        .ram_rden       (ram_rden),
        .ram_wren       (ram_wren),
        .ram_q          (ram_q),
        .out_if         (u_if)
    );

    always #5 clk = ~clk;

    // RAM: data for a read enabled in cycle T appears on ram_q in cycle T+2
    always @(posedge clk) begin
        q1    <= ram_rden ? mem[ram_address] : '0;
        ram_q <= q1;
    end

    typedef struct packed {
        logic [7:0]  id;
        logic        last;
        logic [95:0] pos;
    } exp_t;

    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_err    = 0;
    int   got_words, first_valid, done_t, done_cnt, last_addr;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] make_pos(input int a, input int seed);
        return {32'(a * 7 + seed), 32'hC0DE0000 ^ 32'(seed), 32'(a)};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 128'(busy), 128'(0));
        check({tag, "_done"}, 128'(done), 128'(0));
        check({tag, "_cnt_err"}, 128'(cnt_err), 128'(0));
        check({tag, "_count"}, 128'(particle_count), 128'(0));
        check({tag, "_addr"}, 128'(ram_address), 128'(0));
        check({tag, "_rden"}, 128'(ram_rden), 128'(0));
        check({tag, "_wren"}, 128'(ram_wren), 128'(0));
        check({tag, "_valid"}, 128'(u_if.out_valid), 128'(0));
        check({tag, "_pos"}, 128'(u_if.out_pos), 128'(0));
        check({tag, "_last"}, 128'(u_if.out_last), 128'(0));
    endtask

    // One cell read: loads RAM, queues expected words, starts, then monitors cycle by cycle
    task automatic run_cell(input int cnt, input bit toggle, input int abort_at, input bit extra_start);
        int          n;
        int          t;
        int          issued;
        bit          fin;
        bit          held_v;
        logic [95:0] held_pos;
        logic        held_last;
        logic [95:0] w0;
        exp_t        e;
        n  = (cnt > PN - 1) ? PN - 1 : cnt;
        w0 = '1;
        w0[7:0] = 8'(cnt);
        mem[0] = w0;
        for (int a = 1; a < 256; a++) mem[a] = make_pos(a, cnt);
        exp_q.delete();
        for (int a = 1; a <= n; a++) exp_q.push_back('{id: 8'(a), last: (a == n), pos: make_pos(a, cnt)});
        got_words = 0; first_valid = -1; done_t = -1; done_cnt = 0; last_addr = -1;
        issued = 0; held_v = 1'b0; held_pos = '0; held_last = 1'b0; fin = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        t = 1;
        while (!fin) begin
            if (extra_start) start = (t == 5);
            u_if.out_ready = toggle ? 1'(t % 2) : 1'b1;
            @(negedge clk);
            if (held_v) begin
                check("hold_valid", 128'(u_if.out_valid), 128'(1));
                check("hold_pos", 128'(u_if.out_pos), 128'(held_pos));
                check("hold_last", 128'(u_if.out_last), 128'(held_last));
            end
            held_v    = u_if.out_valid && !u_if.out_ready;
            held_pos  = u_if.out_pos;
            held_last = u_if.out_last;
            if (ram_rden && t > 1) begin
                check("rd_credit_full", 128'((issued - got_words) >= FD), 128'(0));
                check("rd_addr", 128'(ram_address), 128'(issued + 1));
                issued++;
                last_addr = int'(ram_address);
            end
            if (u_if.out_valid && first_valid < 0) first_valid = t;
            if (u_if.out_valid && u_if.out_ready) begin
                check("word_expected", 128'(exp_q.size() != 0), 128'(1));
                e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
                check("out_pos", 128'(u_if.out_pos), 128'(e.pos));
                check("out_last", 128'(u_if.out_last), 128'(e.last));
`ifdef CELL_POS_RD_ID_EN
                check("out_id", 128'(u_if.out_id), 128'(e.id));
`endif
                got_words++;
            end
            if (abort_at >= 0 && got_words == abort_at) begin
                #1 rst = 1'b1;
                #1 check_all_zero("abort");
                start = 1'b0;
                @(posedge clk); #1 rst = 1'b0;
                fin = 1'b1;
            end else begin
                if (done) begin
                    done_cnt++;
                    if (done_t < 0) done_t = t;
                end
                if (done_t >= 0 && t >= done_t + 3) fin = 1'b1;
                if (t > 3000) begin
                    check("timeout_cycles", 128'(t), 128'(0));
                    fin = 1'b1;
                end
                if (!fin) begin
                    @(posedge clk); #1;
                    t++;
                end
            end
        end
        start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        u_if.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset");
        rst = 1'b0;

        // count 5, ready held high
        run_cell(5, 1'b0, -1, 1'b0);
        check("t1_words", 128'(got_words), 128'(5));
        check("t1_first_valid", 128'(first_valid), 128'(7));
        check("t1_done_t", 128'(done_t), 128'(12));
        check("t1_done_cnt", 128'(done_cnt), 128'(1));
        check("t1_count", 128'(particle_count), 128'(5));
        check("t1_cnt_err", 128'(cnt_err), 128'(0));
        check("t1_busy_after", 128'(busy), 128'(0));
        check("t1_last_addr", 128'(last_addr), 128'(5));

        // empty cell
        run_cell(0, 1'b0, -1, 1'b0);
        check("t2_words", 128'(got_words), 128'(0));
        check("t2_no_valid", 128'(first_valid), 128'(-1));
        check("t2_done_t", 128'(done_t), 128'(4));
        check("t2_count", 128'(particle_count), 128'(0));

        // count 10 with back-pressure every other cycle
        run_cell(10, 1'b1, -1, 1'b0);
        check("t3_words", 128'(got_words), 128'(10));
        check("t3_queue_empty", 128'(exp_q.size()), 128'(0));
        check("t3_done_cnt", 128'(done_cnt), 128'(1));
        check("t3_last_addr", 128'(last_addr), 128'(10));

        // count above the RAM depth gets clamped
        run_cell(250, 1'b0, -1, 1'b0);
        check("t4_cnt_err", 128'(cnt_err), 128'(1));
        check("t4_count", 128'(particle_count), 128'(219));
        check("t4_words", 128'(got_words), 128'(219));
        check("t4_last_addr", 128'(last_addr), 128'(219));

        // reset mid-stream, then a clean full stream
        run_cell(8, 1'b0, 3, 1'b0);
        check("t5_words_before_abort", 128'(got_words), 128'(3));
        run_cell(6, 1'b0, -1, 1'b0);
        check("t5_words", 128'(got_words), 128'(6));
        check("t5_first_valid", 128'(first_valid), 128'(7));
        check("t5_done_t", 128'(done_t), 128'(13));
        check("t5_cnt_err_cleared", 128'(cnt_err), 128'(0));
        check("t5_queue_empty", 128'(exp_q.size()), 128'(0));

        // start pulsed while busy is ignored
        run_cell(7, 1'b0, -1, 1'b1);
        check("t6_words", 128'(got_words), 128'(7));
        check("t6_done_cnt", 128'(done_cnt), 128'(1));
        check("t6_done_t", 128'(done_t), 128'(14));
        check("t6_busy_after", 128'(busy), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
